// File: rtl/control_seq_unit_if.sv
// Decode-side and pipeline control bundle of the control sequencing unit.
interface control_seq_unit_if #(
  parameter int ALU_W = 4,
  parameter int IDX_W = 3
);
  logic [5:0]       funct;
  logic [1:0]       opcode;
  logic             valid_d;
  logic             stall_i;
  logic             flush_i;
  logic [1:0]       RegSrcD;
  logic [1:0]       ImmSrcD;
  logic             PCSrcD;
  logic             seq_stall_o;
  logic             illegal_o;
  logic             ALUSrcE;
  logic [ALU_W-1:0] ALUControlE;
  logic [1:0]       FlagWE;
  logic             BranchE;
  logic             PlusOneE;
  logic [IDX_W-1:0] IdxE;
  logic             MemWriteM;
  logic             MemToRegM;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             MemToRegW;

  modport master (
    output funct, opcode, valid_d, stall_i, flush_i,
    input  RegSrcD, ImmSrcD, PCSrcD, seq_stall_o, illegal_o,
    input  ALUSrcE, ALUControlE, FlagWE, BranchE, PlusOneE, IdxE,
    input  MemWriteM, MemToRegM, RegWriteM, RegWriteW, MemToRegW
  );

  modport slave (
    input  funct, opcode, valid_d, stall_i, flush_i,
    output RegSrcD, ImmSrcD, PCSrcD, seq_stall_o, illegal_o,
    output ALUSrcE, ALUControlE, FlagWE, BranchE, PlusOneE, IdxE,
    output MemWriteM, MemToRegM, RegWriteM, RegWriteW, MemToRegW
  );
endinterface

// File: rtl/control_seq_unit.sv
// Pipelined main decoder with an AVERAGE / STR_ONE micro-op sequencer.
// Control bundle is decoded in D and registered through E, M and W.
module control_seq_unit #(
  parameter int ALU_W     = 4,
  parameter int NUM_CH    = 3,
  parameter int BURST_LEN = 4,
  parameter int IDX_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  control_seq_unit_if.slave  bus
);

  localparam logic [3:0] CMD_NOP     = 4'd0;
  localparam logic [3:0] CMD_ADD     = 4'd1;
  localparam logic [3:0] CMD_SUB     = 4'd2;
  localparam logic [3:0] CMD_MULT    = 4'd3;
  localparam logic [3:0] CMD_LOAD    = 4'd4;
  localparam logic [3:0] CMD_STR     = 4'd5;
  localparam logic [3:0] CMD_AVERAGE = 4'd6;
  localparam logic [3:0] CMD_STR_ONE = 4'd7;
  localparam logic [3:0] CMD_PIC     = 4'd8;
  localparam logic [3:0] CMD_B       = 4'd9;

  localparam logic [ALU_W-1:0] ALU_NOP    = '0;
  localparam logic [ALU_W-1:0] ALU_ADD    = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_SUB    = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_MULT   = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_BUFFER = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_AV     = ALU_W'(5);

  localparam logic [IDX_W-1:0] AVG_LAST   = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] BURST_LAST = IDX_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_AVG, S_BURST} state_t;

  typedef struct packed {
    logic             alu_src;
    logic [ALU_W-1:0] alu_ctrl;
    logic [1:0]       flag_w;
    logic             branch;
    logic             plus_one;
    logic [IDX_W-1:0] idx;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
  } bundle_t;

  // Builds the control bundle for one (micro-)op; undefined cmd yields a bubble.
  function automatic bundle_t decode(input logic [4:0]       f,
                                     input logic [1:0]       op,
                                     input logic [IDX_W-1:0] i,
                                     input logic             last);
    logic [3:0] cmd;
    logic       s;
    bundle_t    b;
    cmd = f[4:1];
    s   = f[0];
    b   = '0;
    if (cmd <= CMD_B) begin
      b.alu_src    = op[0];
      b.branch     = (op == 2'b10);
      b.mem_to_reg = (cmd == CMD_LOAD);
      b.mem_write  = (cmd == CMD_STR) || (cmd == CMD_STR_ONE);
      b.reg_write  = !((cmd == CMD_STR) || (cmd == CMD_PIC) || (cmd == CMD_NOP));
      b.flag_w     = {s, s & ((cmd == CMD_ADD) || (cmd == CMD_SUB))};
      b.idx        = i;
      case (cmd)
        CMD_ADD:                         b.alu_ctrl = ALU_ADD;
        CMD_SUB:                         b.alu_ctrl = ALU_SUB;
        CMD_MULT:                        b.alu_ctrl = ALU_MULT;
        CMD_AVERAGE:                     b.alu_ctrl = ALU_AV;
        CMD_LOAD, CMD_STR, CMD_STR_ONE:  b.alu_ctrl = ALU_BUFFER;
        default:                         b.alu_ctrl = ALU_NOP;
      endcase
      // Multi-op sequences only commit architectural state on their final micro-op.
      if (cmd == CMD_AVERAGE && !last) begin
        b.reg_write = 1'b0;
        b.flag_w    = 2'b00;
      end
      if (cmd == CMD_STR_ONE) begin
        b.plus_one  = 1'b1;
        b.mem_write = 1'b1;
        if (!last) b.reg_write = 1'b0;
      end
    end
    return b;
  endfunction

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [4:0]       seq_funct;
  logic [1:0]       seq_opcode;
  logic             accept;
  logic             seq_stall;
  logic [3:0]       cmd_d;
  bundle_t          issue;
  bundle_t          e_q;
  logic             m_mem_write, m_mem_to_reg, m_reg_write;
  logic             w_reg_write, w_mem_to_reg;
  logic             unused_funct;

  assign cmd_d        = bus.funct[4:1];
  assign unused_funct = bus.funct[5];

  // D-stage combinational decode outputs.
  always_comb begin
    bus.RegSrcD   = {(bus.opcode == 2'b01) & ~bus.funct[0], (bus.opcode == 2'b10)};
    bus.ImmSrcD   = {(cmd_d == CMD_B), (cmd_d == CMD_STR) || (cmd_d == CMD_LOAD)};
    bus.PCSrcD    = (bus.opcode == 2'b10) & bus.valid_d;
    bus.illegal_o = bus.valid_d & (cmd_d > CMD_B);
  end

  // Sequencer next state, micro-op issue and fetch freeze.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    issue     = '0;
    seq_stall = 1'b0;
    accept    = bus.valid_d & ~bus.stall_i & ~bus.flush_i & (state == S_IDLE);
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_d == CMD_AVERAGE) begin
            issue = decode(bus.funct[4:0], bus.opcode, '0, NUM_CH == 1);
            if (NUM_CH > 1) begin
              state_n   = S_AVG;
              idx_n     = IDX_W'(1);
              seq_stall = 1'b1;
            end
          end else if (cmd_d == CMD_STR_ONE) begin
            issue = decode(bus.funct[4:0], bus.opcode, '0, BURST_LEN == 1);
            if (BURST_LEN > 1) begin
              state_n   = S_BURST;
              idx_n     = IDX_W'(1);
              seq_stall = 1'b1;
            end
          end else begin
            issue = decode(bus.funct[4:0], bus.opcode, '0, 1'b1);
          end
        end
      end
      S_AVG, S_BURST: begin
        seq_stall = (state == S_AVG) ? (idx != AVG_LAST) : (idx != BURST_LAST);
        if (!bus.stall_i && !bus.flush_i) begin
          issue = decode(seq_funct, seq_opcode, idx, !seq_stall);
          if (seq_stall) begin
            idx_n = idx + IDX_W'(1);
          end else begin
            state_n = S_IDLE;
            idx_n   = '0;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
    endcase
    if (bus.flush_i) begin
      state_n = S_IDLE;
      idx_n   = '0;
    end
    if (!reset) seq_stall = 1'b0;
  end

  assign bus.seq_stall_o = seq_stall;

  // Sequencer state, index and the instruction latched at accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      seq_funct  <= '0;
      seq_opcode <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (accept) begin
        seq_funct  <= bus.funct[4:0];
        seq_opcode <= bus.opcode;
      end
    end
  end

  // E/M/W control pipeline; flush wins over stall, a held E sends a bubble to M.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q          <= '0;
      m_mem_write  <= 1'b0;
      m_mem_to_reg <= 1'b0;
      m_reg_write  <= 1'b0;
      w_reg_write  <= 1'b0;
      w_mem_to_reg <= 1'b0;
    end else begin
      if (bus.flush_i) begin
        e_q          <= '0;
        m_mem_write  <= e_q.mem_write;
        m_mem_to_reg <= e_q.mem_to_reg;
        m_reg_write  <= e_q.reg_write;
      end else if (bus.stall_i) begin
        m_mem_write  <= 1'b0;
        m_mem_to_reg <= 1'b0;
        m_reg_write  <= 1'b0;
      end else begin
        e_q          <= issue;
        m_mem_write  <= e_q.mem_write;
        m_mem_to_reg <= e_q.mem_to_reg;
        m_reg_write  <= e_q.reg_write;
      end
      w_reg_write  <= m_reg_write;
      w_mem_to_reg <= m_mem_to_reg;
    end
  end

  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.ALUControlE = e_q.alu_ctrl;
  assign bus.FlagWE      = e_q.flag_w;
  assign bus.BranchE     = e_q.branch;
  assign bus.PlusOneE    = e_q.plus_one;
  assign bus.IdxE        = e_q.idx;
  assign bus.MemWriteM   = m_mem_write;
  assign bus.MemToRegM   = m_mem_to_reg;
  assign bus.RegWriteM   = m_reg_write;
  assign bus.RegWriteW   = w_reg_write;
  assign bus.MemToRegW   = w_mem_to_reg;

endmodule

// File: tb/tb_control_seq_unit.sv
// Directed bench for control_seq_unit: decode vector table plus sequencer scenarios.
module tb_control_seq_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  control_seq_unit_if #(.ALU_W(4), .IDX_W(3)) bus();

  control_seq_unit #(
    .ALU_W(4),
    .NUM_CH(3),
    .BURST_LEN(4),
    .IDX_W(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] funct;
    logic [1:0] opcode;
    logic       valid;
    logic [1:0] regsrc;
    logic [1:0] immsrc;
    logic       pcsrc;
    logic       illegal;
    logic       alusrc;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       branch;
    logic       mw;
    logic       mtr;
    logic       rw;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.valid_d = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            funct      op     v     regsrc immsrc pc    ill   asrc  alu   flagw  br    mw    mtr   rw
    vecs[0]  = '{6'b000011, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{6'b000100, 2'b01, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{6'b000111, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{6'b001000, 2'b01, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 4'd4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{6'b001010, 2'b01, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 4'd4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{6'b010000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{6'b010010, 2'b10, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{6'b000000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{6'b011110, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{6'b000010, 2'b10, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{6'b001001, 2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 4'd4, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{6'b010100, 2'b01, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{6'b000101, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd2, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held low with a valid ADDS on the decode inputs.
    reset       = 1'b0;
    bus.valid_d = 1'b1;
    bus.funct   = 6'b000011;
    bus.opcode  = 2'b00;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    tick();
    tick();
    chk("rst_alu",      bus.ALUControlE, 4'd0);
    chk("rst_flagw",    bus.FlagWE, 2'b00);
    chk("rst_e_misc",   {bus.ALUSrcE, bus.BranchE, bus.PlusOneE, bus.IdxE}, 6'd0);
    chk("rst_m",        {bus.MemWriteM, bus.MemToRegM, bus.RegWriteM}, 3'd0);
    chk("rst_w",        {bus.RegWriteW, bus.MemToRegW}, 2'd0);
    chk("rst_seqstall", bus.seq_stall_o, 1'b0);
    bus.valid_d = 1'b0;
    reset       = 1'b1;
    idle(3);

    // Decode table: single-cycle instructions followed through E, M and W.
    for (int v = 0; v < 13; v++) begin
      bus.funct   = vecs[v].funct;
      bus.opcode  = vecs[v].opcode;
      bus.valid_d = vecs[v].valid;
      #1;
      chk($sformatf("v%0d_regsrc", v),   bus.RegSrcD, vecs[v].regsrc);
      chk($sformatf("v%0d_immsrc", v),   bus.ImmSrcD, vecs[v].immsrc);
      chk($sformatf("v%0d_pcsrc", v),    bus.PCSrcD, vecs[v].pcsrc);
      chk($sformatf("v%0d_illegal", v),  bus.illegal_o, vecs[v].illegal);
      chk($sformatf("v%0d_seqstall", v), bus.seq_stall_o, 1'b0);
      tick();
      bus.valid_d = 1'b0;
      chk($sformatf("v%0d_alusrcE", v),  bus.ALUSrcE, vecs[v].alusrc);
      chk($sformatf("v%0d_aluE", v),     bus.ALUControlE, vecs[v].alu);
      chk($sformatf("v%0d_flagwE", v),   bus.FlagWE, vecs[v].flagw);
      chk($sformatf("v%0d_branchE", v),  bus.BranchE, vecs[v].branch);
      chk($sformatf("v%0d_plusidxE", v), {bus.PlusOneE, bus.IdxE}, 4'd0);
      tick();
      chk($sformatf("v%0d_memwriteM", v), bus.MemWriteM, vecs[v].mw);
      chk($sformatf("v%0d_memtoregM", v), bus.MemToRegM, vecs[v].mtr);
      chk($sformatf("v%0d_regwriteM", v), bus.RegWriteM, vecs[v].rw);
      tick();
      chk($sformatf("v%0d_regwriteW", v), bus.RegWriteW, vecs[v].rw);
      chk($sformatf("v%0d_memtoregW", v), bus.MemToRegW, vecs[v].mtr);
    end
    idle(2);

    // FAVERAGE with S=1: three AV micro-ops, only the last writes reg/flags.
    bus.funct   = 6'b001101;
    bus.opcode  = 2'b00;
    bus.valid_d = 1'b1;
    #1;
    chk("avg_ss_t0", bus.seq_stall_o, 1'b1);
    tick();
    bus.funct = 6'b000100;   // SUB on D must be ignored mid-sequence
    #1;
    chk("avg_ss_t1",   bus.seq_stall_o, 1'b1);
    chk("avg_idx_t1",  bus.IdxE, 3'd0);
    chk("avg_alu_t1",  bus.ALUControlE, 4'd5);
    chk("avg_flag_t1", bus.FlagWE, 2'b00);
    tick();
    chk("avg_ss_t2",   bus.seq_stall_o, 1'b0);
    chk("avg_idx_t2",  bus.IdxE, 3'd1);
    chk("avg_alu_t2",  bus.ALUControlE, 4'd5);
    chk("avg_flag_t2", bus.FlagWE, 2'b00);
    chk("avg_rwM_t2",  bus.RegWriteM, 1'b0);
    bus.valid_d = 1'b0;
    tick();
    chk("avg_idx_t3",  bus.IdxE, 3'd2);
    chk("avg_alu_t3",  bus.ALUControlE, 4'd5);
    chk("avg_flag_t3", bus.FlagWE, 2'b10);
    chk("avg_rwM_t3",  bus.RegWriteM, 1'b0);
    tick();
    chk("avg_alu_t4",  bus.ALUControlE, 4'd0);
    chk("avg_rwM_t4",  bus.RegWriteM, 1'b1);
    tick();
    chk("avg_rwM_t5",  bus.RegWriteM, 1'b0);
    chk("avg_rwW_t5",  bus.RegWriteW, 1'b1);
    idle(2);

    // FSTR_ONE burst of four with a stall while beat 2 is due.
    begin
      logic [2:0] e_idx [8];
      logic       e_plus[8];
      logic       e_mw  [8];
      logic       e_rw  [8];
      logic       e_ss  [8];
      int         beats;
      e_idx  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
      e_plus = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      e_mw   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      e_rw   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      e_ss   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      beats  = 0;
      bus.funct   = 6'b001110;
      bus.opcode  = 2'b01;
      bus.valid_d = 1'b1;
      #1;
      chk("bst_ss_k0", bus.seq_stall_o, e_ss[0]);
      tick();
      bus.valid_d = 1'b0;
      for (int k = 1; k < 8; k++) begin
        bus.stall_i = (k == 2);
        #1;
        chk($sformatf("bst_idxE_k%0d", k),  bus.IdxE, e_idx[k]);
        chk($sformatf("bst_plusE_k%0d", k), bus.PlusOneE, e_plus[k]);
        chk($sformatf("bst_mwM_k%0d", k),   bus.MemWriteM, e_mw[k]);
        chk($sformatf("bst_rwM_k%0d", k),   bus.RegWriteM, e_rw[k]);
        chk($sformatf("bst_ss_k%0d", k),    bus.seq_stall_o, e_ss[k]);
        if (bus.MemWriteM === 1'b1) beats++;
        tick();
      end
      bus.stall_i = 1'b0;
      chk("bst_beats", beats, 4);
    end
    idle(2);

    // Flush together with stall during AVG idx=1, then a normal ADD.
    bus.funct   = 6'b001101;
    bus.opcode  = 2'b00;
    bus.valid_d = 1'b1;
    tick();
    bus.valid_d = 1'b0;
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    tick();
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    chk("fl_aluE",  bus.ALUControlE, 4'd0);
    chk("fl_idxE",  bus.IdxE, 3'd0);
    chk("fl_flagE", bus.FlagWE, 2'b00);
    chk("fl_ss",    bus.seq_stall_o, 1'b0);
    chk("fl_rwM",   bus.RegWriteM, 1'b0);
    bus.funct   = 6'b000010;
    bus.valid_d = 1'b1;
    #1;
    chk("fl_ss_add", bus.seq_stall_o, 1'b0);
    tick();
    bus.valid_d = 1'b0;
    chk("fl_add_aluE", bus.ALUControlE, 4'd1);
    chk("fl_add_idxE", bus.IdxE, 3'd0);
    chk("fl_add_rwM0", bus.RegWriteM, 1'b0);
    tick();
    chk("fl_add_rwM1", bus.RegWriteM, 1'b1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
